// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer for an external 1-bit ALU cell.
// Operands are fed to the cell LSB-first, one bit per clock.
// The ripple carry is kept in a register between bits.
// The result word is assembled internally and published on entry to FIN.
// Completion is reported with a one-cycle DONE pulse.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic [2:0]       ALU_MODE,
    output logic             ALU_A,
    output logic             ALU_B,
    output logic             ALU_CIN,
    input  logic             ALU_X,
    input  logic             ALU_COUT
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [2:0]     MODE_MAX = 3'b100;  // highest valid op code (XNOR)

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa_sh;
    logic [WIDTH-1:0] r_opb_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [2:0]       r_mode;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_err;

    logic             w_accept;
    logic             w_valid;
    logic             w_run;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && START;
    assign w_valid  = (MODE <= MODE_MAX);
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: clocked state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> RUN (valid mode) or FIN (invalid), RUN -> FIN after last bit.
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = w_valid ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_opa_sh    <= '0;
            r_opb_sh    <= '0;
            r_res_sh    <= '0;
            r_mode      <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_result    <= '0;
            r_carry_out <= 1'b0;
            if (w_valid) begin
                r_opa_sh <= OPA;
                r_opb_sh <= OPB;
                r_mode   <= MODE;
                r_res_sh <= '0;
                r_cnt    <= '0;
                r_carry  <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                // Invalid op: mode register keeps the last good mode on ALU_MODE.
                r_err <= 1'b1;
            end
        end else if (w_run) begin
            r_res_sh <= {ALU_X, r_res_sh[WIDTH-1:1]};
            r_opa_sh <= {1'b0, r_opa_sh[WIDTH-1:1]};
            r_opb_sh <= {1'b0, r_opb_sh[WIDTH-1:1]};
            r_carry  <= ALU_COUT;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                // Copy the completed word so RESULT never shows a partial value.
                r_result    <= {ALU_X, r_res_sh[WIDTH-1:1]};
                r_carry_out <= ALU_COUT;
            end
        end
    end

    // Outputs: ALU bit inputs are only active during RUN.
    assign BUSY     = (r_state != S_IDLE);
    assign DONE     = (r_state == S_FIN);
    assign ERR      = r_err;
    assign RESULT   = r_result;
    assign CARRY    = r_carry_out;
    assign ALU_MODE = r_mode;
    assign ALU_A    = w_run & r_opa_sh[0];
    assign ALU_B    = w_run & r_opb_sh[0];
    assign ALU_CIN  = w_run & r_carry;

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Bit-serial sequencer for the 1-bit ALU cell (Mode/A/B/C_in -> X/C_out). It accepts WIDTH-bit operands and a 3-bit mode, then drives the single ALU cell LSB-first, one bit per clock. It keeps the ripple carry in a register between bits, assembles the result word and reports completion with a one-cycle DONE pulse. The ALU cell stays an external combinational instance wired to the ALU_* ports.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
START  in  1  request; sampled only in IDLE
MODE  in  3  op code: 000 add, 001 AND, 010 OR, 011 XOR, 100 XNOR; 101-111 invalid
OPA  in  WIDTH  operand A, latched on accepted START
OPB  in  WIDTH  operand B, latched on accepted START
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle completion pulse
ERR  out  1  invalid MODE flag, valid with DONE, held until next accept
RESULT  out  WIDTH  result word, held until next accepted START
CARRY  out  1  final carry (add only, else 0), held with RESULT
ALU_MODE  out  3  to ALU Mode
ALU_A  out  1  to ALU A
ALU_B  out  1  to ALU B
ALU_CIN  out  1  to ALU C_in
ALU_X  in  1  from ALU X
ALU_COUT  in  1  from ALU C_out

Behaviour:
- Reset: state=IDLE; BUSY=DONE=ERR=CARRY=0; RESULT=0; ALU_MODE=000; ALU_A=ALU_B=ALU_CIN=0; bit counter=0; carry reg=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - On START=1 with MODE<=100: latch OPA/OPB into shift regs and MODE into mode reg; clear carry reg, counter, RESULT, CARRY and ERR; go to RUN.
  - On START=1 with MODE>=101: set ERR=1, RESULT=0, CARRY=0; go to FIN.
  - Otherwise hold.
- RUN, one bit per cycle:
  - Drive ALU_A=opa_sh[0], ALU_B=opb_sh[0], ALU_CIN=carry reg, ALU_MODE=mode reg.
  - At the clock edge: shift ALU_X into the RESULT shift reg at the MSB end (shift right); carry reg <= ALU_COUT; shift both operand regs right; counter++.
  - After the bit with counter==WIDTH-1: CARRY <= ALU_COUT; go to FIN.
- ALU_COUT is 0 by construction for non-add modes, and CARRY=0 in those modes. The controller does not mask it.
- FIN: DONE=1 for exactly this cycle; BUSY=1; next state IDLE.
- In IDLE and FIN, ALU_A/ALU_B/ALU_CIN=0 and ALU_MODE holds the last latched mode.
- Latency: START sampled at edge 0. RUN covers cycles 1..WIDTH, DONE is high in cycle WIDTH+1, and the next START is accepted at cycle WIDTH+2. Invalid mode: DONE in cycle 1.
- START while BUSY=1 (RUN or FIN) is ignored and has no side effect.
- RESULT/CARRY must not change during RUN from the previous op's view until the word completes. Build the result in an internal shift reg and copy it to RESULT on entry to FIN.
- Arithmetic: add is unsigned modulo 2^WIDTH; CARRY is bit WIDTH of the sum.
- RST mid-operation: return to IDLE with all outputs at reset values next cycle; no DONE pulse.
- OPA/OPB/MODE changes after acceptance do not affect the op in flight.

Test Plan:
- WIDTH=8, MODE=000, OPA=A5, OPB=5B, START one cycle -> BUSY cycles 1..9, DONE only in cycle 9, RESULT=00, CARRY=1, ERR=0.
- MODE=001, OPA=F0, OPB=3C -> RESULT=30, CARRY=0. Then MODE=100, OPA=AA, OPB=0F -> RESULT=5A, CARRY=0.
- MODE=110 with START -> DONE in cycle 1, ERR=1, RESULT=00, CARRY=0, no ALU_A/ALU_B activity.
- Add FF+01, with START re-pulsed and OPA changed to 00 during RUN -> second START ignored, RESULT=00, CARRY=1, exactly one DONE.
- RST asserted at cycle 4 of an add -> next cycle IDLE, BUSY=0, RESULT=00, no DONE. A fresh START then completes normally with 12+34 -> RESULT=46, CARRY=0.
